// File: rtl/ni_packetizer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ni_packetizer_pkg
// Brief    : Flit bit positions, head-field offsets and FSM state encodings
// Revision : 1.0
// ============================================================================
package ni_packetizer_pkg;

    localparam int FLIT_W     = 32;
    localparam int PAYLOAD_W  = 29;

    localparam int VALID_B    = 31;
    localparam int HEAD_B     = 30;
    localparam int TAIL_B     = 29;

    localparam int DEST_X_LSB = 24;
    localparam int DEST_Y_LSB = 20;
    localparam int LEN_LSB    = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ni_packetizer_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : ni_packetizer_credit_counter
// Brief    : Downstream buffer credit tracker with sticky overflow flag
// Revision : 1.0
// ============================================================================
module ni_packetizer_credit_counter #(
    parameter int BUF_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic credit_in,
    input  logic consume,
    output logic has_credit,
    output logic overflow
);

    localparam int              CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= C_FULL;
            r_overflow <= 1'b0;
        end else if (credit_in && !consume) begin
            // A return at full credit means the inport freed a slot we never used.
            if (r_count == C_FULL) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + C_ONE;
            end
        end else if (!credit_in && consume) begin
            r_count <= r_count - C_ONE;
        end
    end

    assign has_credit = (r_count != '0);
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ni_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : ni_packetizer
// Brief    : PE-side NI injector building head/body/tail flits under credit flow control
// Revision : 1.0
// ============================================================================
module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int ADDR_W    = 4,
    parameter int LEN_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pe_req_valid,
    output logic                 pe_req_ready,
    input  logic [ADDR_W-1:0]    pe_dest_x,
    input  logic [ADDR_W-1:0]    pe_dest_y,
    input  logic [LEN_W-1:0]     pe_len,
    input  logic                 pe_data_valid,
    output logic                 pe_data_ready,
    input  logic [PAYLOAD_W-1:0] pe_data,
    input  logic                 credit_in,
    output logic [FLIT_W-1:0]    channel_out,
    output logic                 busy,
    output logic                 credit_err
);

    localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_dest_x;
    logic [ADDR_W-1:0] r_dest_y;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_remaining;
    logic [FLIT_W-1:0] r_channel;

    logic              w_has_credit;
    logic              w_send_head;
    logic              w_send_body;
    logic              w_consume;
    logic [FLIT_W-1:0] w_flit;

    ni_packetizer_credit_counter #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_credit_counter (
        .clk        (clk),
        .rst        (rst),
        .credit_in  (credit_in),
        .consume    (w_consume),
        .has_credit (w_has_credit),
        .overflow   (credit_err)
    );

    assign w_send_head   = (r_state == ST_HEAD) && w_has_credit;
    assign pe_data_ready = (r_state == ST_BODY) && w_has_credit;
    assign w_send_body   = pe_data_valid && pe_data_ready;
    assign w_consume     = w_send_head || w_send_body;

    always_comb begin
        w_flit = '0;
        if (w_send_head) begin
            w_flit[VALID_B]                   = 1'b1;
            w_flit[HEAD_B]                    = 1'b1;
            w_flit[TAIL_B]                    = (r_len == '0);
            w_flit[DEST_X_LSB +: ADDR_W]      = r_dest_x;
            w_flit[DEST_Y_LSB +: ADDR_W]      = r_dest_y;
            w_flit[LEN_LSB +: LEN_W]          = r_len;
        end else if (w_send_body) begin
            w_flit[VALID_B]                   = 1'b1;
            w_flit[TAIL_B]                    = (r_remaining == C_LEN_ONE);
            w_flit[PAYLOAD_W-1:0]             = pe_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_dest_x    <= '0;
            r_dest_y    <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_channel   <= '0;
        end else begin
            r_channel <= w_flit;
            case (r_state)
                ST_IDLE: begin
                    if (pe_req_valid) begin
                        r_dest_x    <= pe_dest_x;
                        r_dest_y    <= pe_dest_y;
                        r_len       <= pe_len;
                        r_remaining <= pe_len;
                        r_state     <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (w_send_head) begin
                        r_state <= (r_len == '0) ? ST_IDLE : ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (w_send_body) begin
                        r_remaining <= r_remaining - C_LEN_ONE;
                        if (r_remaining == C_LEN_ONE) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign channel_out  = r_channel;
    assign busy         = (r_state != ST_IDLE);
    assign pe_req_ready = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ni_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ni_packetizer
// Brief    : Directed self-checking bench for ni_packetizer
// Revision : 1.0
// ============================================================================
module tb_ni_packetizer;

    logic        clk;
    logic        rst;
    logic        pe_req_valid;
    logic        pe_req_ready;
    logic [3:0]  pe_dest_x;
    logic [3:0]  pe_dest_y;
    logic [7:0]  pe_len;
    logic        pe_data_valid;
    logic        pe_data_ready;
    logic [28:0] pe_data;
    logic        credit_in;
    logic [31:0] channel_out;
    logic        busy;
    logic        credit_err;

    int tests_run;
    int tests_failed;

    ni_packetizer #(
        .BUF_DEPTH (4),
        .ADDR_W    (4),
        .LEN_W     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pe_req_valid  (pe_req_valid),
        .pe_req_ready  (pe_req_ready),
        .pe_dest_x     (pe_dest_x),
        .pe_dest_y     (pe_dest_y),
        .pe_len        (pe_len),
        .pe_data_valid (pe_data_valid),
        .pe_data_ready (pe_data_ready),
        .pe_data       (pe_data),
        .credit_in     (credit_in),
        .channel_out   (channel_out),
        .busy          (busy),
        .credit_err    (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic credits_chk(input string tag, input int exp);
        chk(tag, 32'(dut.u_credit_counter.r_count), 32'(exp));
    endtask

    task automatic return_credits(input int n);
        credit_in = 1'b1;
        repeat (n) step();
        credit_in = 1'b0;
    endtask

    task automatic request(input logic [3:0] x, input logic [3:0] y, input logic [7:0] len);
        pe_req_valid = 1'b1;
        pe_dest_x    = x;
        pe_dest_y    = y;
        pe_len       = len;
        step();
        pe_req_valid = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b0;
        pe_req_valid  = 1'b0;
        pe_dest_x     = '0;
        pe_dest_y     = '0;
        pe_len        = '0;
        pe_data_valid = 1'b0;
        pe_data       = '0;
        credit_in     = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_channel", channel_out, 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", pe_req_ready, 1);
        credits_chk("rst_credits", 4);
        chk("rst_credit_err", credit_err, 0);
        rst = 1'b1;
        step();
        chk("rel_channel", channel_out, 32'h0);
        chk("rel_busy", busy, 0);
        chk("rel_req_ready", pe_req_ready, 1);
        credits_chk("rel_credits", 4);

        // Single packet dest (2,3) len 2
        request(4'd2, 4'd3, 8'd2);
        pe_data_valid = 1'b1;
        pe_data       = 29'h1;
        chk("p1_busy", busy, 1);
        chk("p1_req_ready", pe_req_ready, 0);
        chk("p1_data_ready_in_head", pe_data_ready, 0);
        chk("p1_idle_ch", channel_out, 32'h0);
        step();
        chk("p1_head", channel_out, 32'hC230_2000);
        chk("p1_data_ready", pe_data_ready, 1);
        step();
        chk("p1_body1", channel_out, 32'h8000_0001);
        pe_data = 29'h2;
        step();
        chk("p1_tail", channel_out, 32'hA000_0002);
        chk("p1_done_busy", busy, 0);
        pe_data_valid = 1'b0;
        step();
        chk("p1_after_ch", channel_out, 32'h0);
        credits_chk("p1_credits", 1);
        return_credits(3);
        credits_chk("p1_restored", 4);
        chk("p1_no_err", credit_err, 0);

        // Credit starvation: len 6 with only 4 credits
        request(4'd3, 4'd4, 8'd6);
        pe_data_valid = 1'b1;
        pe_data       = 29'h11;
        step();
        chk("st_head", channel_out, 32'hC340_6000);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("st_body%0d", k), channel_out, 32'h8000_0010 + 32'(k));
            pe_data = 29'h10 + 29'(k + 1);
        end
        credits_chk("st_zero", 0);
        chk("st_ready_low", pe_data_ready, 0);
        step();
        chk("st_stall_ch", channel_out, 32'h0);
        chk("st_stall_busy", busy, 1);
        for (int k = 4; k <= 6; k++) begin
            credit_in = 1'b1;
            step();
            credit_in = 1'b0;
            chk($sformatf("st_gap%0d", k), channel_out, 32'h0);
            chk($sformatf("st_ready%0d", k), pe_data_ready, 1);
            step();
            chk($sformatf("st_rel%0d", k), channel_out,
                ((k == 6) ? 32'hA000_0000 : 32'h8000_0000) | (32'h10 + 32'(k)));
            pe_data = 29'h10 + 29'(k + 1);
        end
        pe_data_valid = 1'b0;
        chk("st_done", busy, 0);
        return_credits(4);
        credits_chk("st_restored", 4);

        // Head-only packet
        request(4'd1, 4'd1, 8'd0);
        chk("ho_ready_head", pe_data_ready, 0);
        step();
        chk("ho_flit", channel_out, 32'hE110_0000);
        chk("ho_idle", busy, 0);
        chk("ho_ready_idle", pe_data_ready, 0);
        step();
        chk("ho_after", channel_out, 32'h0);
        return_credits(1);

        // Simultaneous credit return and send, then overflow
        request(4'd0, 4'd0, 8'd1);
        step();
        credits_chk("sim_pre", 3);
        pe_data_valid = 1'b1;
        pe_data       = 29'h5;
        credit_in     = 1'b1;
        step();
        pe_data_valid = 1'b0;
        chk("sim_flit", channel_out, 32'hA000_0005);
        credits_chk("sim_unchanged", 3);
        step();
        credits_chk("sim_full", 4);
        chk("sim_no_err", credit_err, 0);
        step();
        credit_in = 1'b0;
        chk("ovf_err", credit_err, 1);
        credits_chk("ovf_count", 4);

        // Reset mid-BODY, applied between clock edges
        request(4'd7, 4'd2, 8'd3);
        step();
        pe_data_valid = 1'b1;
        pe_data       = 29'h9;
        step();
        chk("mb_body_before", channel_out, 32'h8000_0009);
        pe_data_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mb_async_ch", channel_out, 32'h0);
        chk("mb_async_busy", busy, 0);
        credits_chk("mb_credits", 4);
        chk("mb_err_clr", credit_err, 0);
        step();
        rst = 1'b1;
        step();
        chk("mb_idle", pe_req_ready, 1);
        request(4'd5, 4'd6, 8'd1);
        pe_data_valid = 1'b1;
        pe_data       = 29'h1ABCDEF;
        step();
        chk("mb_new_head", channel_out, 32'hC560_1000);
        step();
        chk("mb_new_tail", channel_out, 32'hA1AB_CDEF);
        pe_data_valid = 1'b0;
        step();
        chk("mb_new_idle", channel_out, 32'h0);
        credits_chk("mb_new_credits", 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
